// File: rtl/dct_sched.sv
// Shares one 2-D DCT engine among NUM_REQ block sources: round-robin grant,
// engine start/latency timing, buffer release and a valid/ready result port.
module dct_sched #(
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2,
  parameter int LATENCY = 24,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] src_req,
  output logic [NUM_REQ-1:0] src_release,
  output logic [SEL_W-1:0]   pix_sel,
  output logic               dct_enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_tag,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int               LAT_W    = $clog2(LATENCY) + 1;
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, START, RUN, DONE, OUT} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] arb_sel;
  int               arb_idx;
  logic             found;
  logic             accept;
  logic             arb_cycle;

  // Round-robin scan starting just after the previous winner
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    arb_sel = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = (int'(last) + i) % NUM_REQ;
      arb_sel = SEL_W'(arb_idx);
      if (!found && src_req[arb_sel]) begin
        found  = 1'b1;
        winner = arb_sel;
      end
    end
  end

  assign accept    = (state == OUT) && out_ready;
  assign arb_cycle = (state == IDLE) || accept;

  always_comb begin
    state_nxt   = state;
    dct_enable  = 1'b0;
    out_valid   = 1'b0;
    out_tag     = '0;
    src_release = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (found) state_nxt = START;
      START: begin
        dct_enable = 1'b1;
        state_nxt  = RUN;
      end
      RUN:   if (cnt == '0) state_nxt = DONE;
      DONE:  begin
        src_release = NUM_REQ'(1) << pix_sel;
        state_nxt   = OUT;
      end
      OUT:   begin
        out_valid = 1'b1;
        out_tag   = pix_sel;
        if (accept) state_nxt = found ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pix_sel is only rewritten on a grant, so it holds from START through OUT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pix_sel <= '0;
      last    <= LAST_RST;
      blk_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == START)
        cnt <= LAT_W'(LATENCY - 2);
      else if (state == RUN && cnt != '0)
        cnt <= cnt - 1'b1;
      if (arb_cycle && found) begin
        pix_sel <= winner;
        last    <= winner;
      end
      if (accept)
        blk_cnt <= blk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dct_sched.sv
// Randomised and directed bench for dct_sched against a timestamp-based
// transaction model of grant order, engine latency and handshake.
module tb_dct_sched;
  localparam int NUM_REQ = 3;
  localparam int SEL_W   = 2;
  localparam int LATENCY = 24;
  localparam int CNT_W   = 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_REQ-1:0] src_req = '0;
  logic [NUM_REQ-1:0] src_release;
  logic [SEL_W-1:0]   pix_sel;
  logic               dct_enable;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [SEL_W-1:0]   out_tag;
  logic               busy;
  logic [CNT_W-1:0]   blk_cnt;

  always #5 clock = ~clock;

  dct_sched #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .src_req(src_req), .src_release(src_release),
    .pix_sel(pix_sel), .dct_enable(dct_enable), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .busy(busy), .blk_cnt(blk_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Source behaviour: blocks queued per source, optional forced drop of src_req
  int                 pending[NUM_REQ];
  logic [NUM_REQ-1:0] drop_mask = '0;
  int                 rdy_mode  = 0;
  int                 bp_seen   = 0;

  // Reference model state: one block in flight, described by its timestamps
  bit m_busy;
  int m_src, m_last, m_pix, m_cnt, en_t, rel_t, ov_t, total_acc;
  bit wrap_due;
  int en_src[$];
  int en_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (req[SEL_W'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_src     = 0;
    m_last    = NUM_REQ - 1;
    m_pix     = 0;
    m_cnt     = 0;
    en_t      = -100;
    rel_t     = -100;
    ov_t      = -100;
    total_acc = 0;
    wrap_due  = 1'b0;
  endtask

  task automatic model_check();
    bit                 ov;
    logic [NUM_REQ-1:0] rel_exp;
    int                 w;
    ov      = m_busy && cyc >= ov_t;
    rel_exp = (m_busy && cyc == rel_t) ? NUM_REQ'(1) << m_src : '0;
    check("dct_enable",  32'(dct_enable),  32'(m_busy && cyc == en_t));
    check("src_release", 32'(src_release), 32'(rel_exp));
    check("out_valid",   32'(out_valid),   32'(ov));
    check("out_tag",     32'(out_tag),     ov ? 32'(m_src) : 32'd0);
    check("pix_sel",     32'(pix_sel),     32'(m_pix));
    check("busy",        32'(busy),        32'(m_busy));
    check("blk_cnt",     32'(blk_cnt),     32'(m_cnt));
    if (wrap_due) begin
      check("wrap17", 32'(blk_cnt), 32'd1);
      wrap_due = 1'b0;
    end
    if (rdy_mode == 2 && ov) bp_seen++;
    if (!m_busy || (ov && out_ready)) begin
      if (m_busy) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        total_acc++;
        if (total_acc == 17) wrap_due = 1'b1;
      end
      w = rr_pick(src_req, m_last);
      if (w < 0) m_busy = 1'b0;
      else begin
        m_busy = 1'b1;
        m_src  = w;
        m_last = w;
        m_pix  = w;
        en_t   = cyc + 1;
        rel_t  = cyc + 1 + LATENCY;
        ov_t   = cyc + 2 + LATENCY;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    for (int j = 0; j < NUM_REQ; j++)
      src_req[SEL_W'(j)] = (pending[j] > 0) && !drop_mask[SEL_W'(j)];
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = (bp_seen >= 10);
    endcase
    @(negedge clock);
    if (dct_enable) begin
      en_src.push_back(int'(pix_sel));
      en_cyc.push_back(cyc);
    end
    model_check();
    for (int j = 0; j < NUM_REQ; j++)
      if (src_release[SEL_W'(j)] && pending[j] > 0) pending[j]--;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   32'(dct_enable),  32'd0);
    check({tag, "_rel"},  32'(src_release), 32'd0);
    check({tag, "_ov"},   32'(out_valid),   32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_pix"},  32'(pix_sel),     32'd0);
    check({tag, "_tag"},  32'(out_tag),     32'd0);
    check({tag, "_cnt"},  32'(blk_cnt),     32'd0);
  endtask

  initial begin
    for (int j = 0; j < NUM_REQ; j++) pending[j] = 0;
    model_reset();
    #2;
    check_all_zero("por");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_check();

    // Single block from source 1
    while (cyc < 9) step();
    pending[1] = 1;
    repeat (40) step();
    check("single_nblk", 32'(en_src.size()), 32'd1);
    if (en_src.size() >= 1) check("single_src", 32'(en_src[0]), 32'd1);

    // Abort source 2 mid-RUN, then sources 0 and 2 compete
    pending[2] = 1;
    for (int i = 0; i < 300 && !(m_busy && m_src == 2 && cyc == en_t + 13); i++) step();
    check("rst_trigger", 32'(m_busy && m_src == 2 && cyc == en_t + 13), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    pending[0] = 1;
    src_req[0] = 1'b1;
    check("rst_norel", 32'(pending[2]), 32'd1);
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset_n = 1'b1;
    en_src.delete();
    en_cyc.delete();
    model_check();
    repeat (70) step();
    check("rst_nblk", 32'(en_src.size()), 32'd2);
    if (en_src.size() >= 2) begin
      check("rst_first",  32'(en_src[0]), 32'd0);
      check("rst_second", 32'(en_src[1]), 32'd2);
    end

    // Round-robin with all sources requesting, ready held high
    for (int j = 0; j < NUM_REQ; j++) pending[j] = 2;
    en_src.delete();
    en_cyc.delete();
    repeat (6 * (LATENCY + 2) + 10) step();
    check("rr_nblk", 32'(en_src.size()), 32'd6);
    for (int k = 0; k < 6 && k < en_src.size(); k++) begin
      check("rr_order", 32'(en_src[k]), 32'(k % 3));
      if (k > 0) check("rr_period", 32'(en_cyc[k] - en_cyc[k-1]), 32'(LATENCY + 2));
    end

    // Backpressure: ready low for 10 cycles of out_valid, 0 and 2 pending
    pending[0] = 1;
    pending[2] = 1;
    bp_seen    = 0;
    rdy_mode   = 2;
    out_ready  = 1'b0;
    en_src.delete();
    en_cyc.delete();
    repeat (90) step();
    check("bp_nblk", 32'(en_src.size()), 32'd2);
    if (en_src.size() >= 2)
      check("bp_gap", 32'(en_cyc[1] - en_cyc[0]), 32'(LATENCY + 1 + 10 + 1));

    // Source 0 drops its request during RUN
    rdy_mode   = 0;
    pending[0] = 1;
    for (int i = 0; i < 300 && !(m_busy && m_src == 0 && cyc == en_t + 5); i++) step();
    check("drop_trigger", 32'(m_busy && m_src == 0 && cyc == en_t + 5), 32'd1);
    drop_mask[0] = 1'b1;
    repeat (40) step();
    check("drop_released", 32'(pending[0]), 32'd0);
    drop_mask = '0;

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int s;
        s = $urandom_range(0, NUM_REQ - 1);
        if (pending[s] < 3) pending[s]++;
      end
      if ($urandom_range(0, 199) == 0) drop_mask = NUM_REQ'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) drop_mask = '0;
      step();
    end
    drop_mask = '0;
    rdy_mode  = 0;
    for (int j = 0; j < NUM_REQ; j++) pending[j] = 0;
    repeat (60) step();
    check("drain_idle", 32'(busy), 32'd0);
    check("acc_total_ge17", 32'(total_acc >= 17), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
